fifo_check_monitor: RTL and testbench

Synthesizable, parametrised protocol checker that passively snoops a synchronous FIFO's write/read ports and status flags, runs a cycle-accurate shadow model, and flags every mismatch in hardware. It succeeds the simulation-only monitor/scoreboard pair, so the same checks run in emulation and FPGA bring-up. It sits beside the FIFO under check, with no path back into it, and exports pass/fail counters plus first-error capture.

---
 rtl/fifo_chk_pkg.sv | 25 ++
 rtl/fifo_ref_model.sv | 82 ++++++++
 rtl/fifo_check_monitor.sv | 140 ++++++++++++++
 tb/tb_fifo_check_monitor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_chk_pkg.sv
// Shared constants and types for the synthesizable FIFO protocol checker.
// Expectation data is carried at MAX_DATA_W bits, so DATA_W may not exceed it.
package fifo_chk_pkg;

  localparam int ERR_DOUT   = 0;
  localparam int ERR_WRACK  = 1;
  localparam int ERR_OVF    = 2;
  localparam int ERR_UDF    = 3;
  localparam int ERR_FULL   = 4;
  localparam int ERR_AFULL  = 5;
  localparam int ERR_EMPTY  = 6;
  localparam int ERR_AEMPTY = 7;

  localparam int MAX_DATA_W = 64;

  typedef logic [7:0] chk_mask_t;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] data;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
  } fifo_exp_t;

endpackage

// File: rtl/fifo_ref_model.sv
// Cycle-accurate shadow of the FIFO under check: memory, pointers, count,
// accept rules and the registered expectations for the next compare.
module fifo_ref_model
  import fifo_chk_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  input  logic [DATA_W-1:0]     data_in_i,
  output logic [MAX_DATA_W-1:0] exp_data_o,
  output logic                  exp_wr_ack_o,
  output logic                  exp_overflow_o,
  output logic                  exp_underflow_o,
  output logic                  exp_full_o,
  output logic                  exp_afull_o,
  output logic                  exp_empty_o,
  output logic                  exp_aempty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wr_acc, rd_acc;
  fifo_exp_t         exp_q, exp_d;
  logic [3:0]        flags_q, flags_d;

  // Full rejects any write (even with a read); empty rejects any read.
  always_comb begin
    wr_acc = wr_en_i && (cnt_q != CW'(DEPTH));
    rd_acc = rd_en_i && (cnt_q != '0);
    wptr_d = wptr_q + AW'(wr_acc);
    rptr_d = rptr_q + AW'(rd_acc);
    cnt_d  = cnt_q + CW'(wr_acc) - CW'(rd_acc);
    exp_d           = exp_q;
    exp_d.wr_ack    = wr_acc;
    exp_d.overflow  = wr_en_i && !wr_acc;
    exp_d.underflow = rd_en_i && !rd_acc;
    if (rd_acc) begin
      exp_d.data = MAX_DATA_W'(mem_q[rptr_q]);
    end
    flags_d = {cnt_d == CW'(DEPTH), cnt_d == CW'(AF_LVL),
               cnt_d == '0,         cnt_d == CW'(AE_LVL)};
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wptr_q] <= data_in_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      flags_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      flags_q <= flags_d;
    end
  end

  assign exp_data_o      = exp_q.data;
  assign exp_wr_ack_o    = exp_q.wr_ack;
  assign exp_overflow_o  = exp_q.overflow;
  assign exp_underflow_o = exp_q.underflow;
  assign {exp_full_o, exp_afull_o, exp_empty_o, exp_aempty_o} = flags_q;

endmodule

// File: rtl/fifo_check_monitor.sv
// Passive FIFO protocol checker: compares snooped outputs with the shadow
// model's expectations and keeps saturating pass/fail counters and first-error capture.
module fifo_check_monitor
  import fifo_chk_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  input  logic              full,
  input  logic              almostfull,
  input  logic              empty,
  input  logic              almostempty,
  input  logic              wr_ack,
  input  logic              overflow,
  input  logic              underflow,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [7:0]        err_mask,
  output logic [7:0]        first_err_mask,
  output logic [CNT_W-1:0]  first_err_cyc,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  logic [MAX_DATA_W-1:0] exp_data;
  logic exp_wr_ack, exp_ovf, exp_udf, exp_full, exp_afull, exp_empty, exp_aempty;

  fifo_ref_model #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL)
  ) u_model (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en_i        (wr_en),
    .rd_en_i        (rd_en),
    .data_in_i      (data_in),
    .exp_data_o     (exp_data),
    .exp_wr_ack_o   (exp_wr_ack),
    .exp_overflow_o (exp_ovf),
    .exp_underflow_o(exp_udf),
    .exp_full_o     (exp_full),
    .exp_afull_o    (exp_afull),
    .exp_empty_o    (exp_empty),
    .exp_aempty_o   (exp_aempty)
  );

  chk_mask_t        cmp_mask;
  logic             check_valid_q;
  logic             err_pulse_q, err_pulse_d, err_sticky_q, err_sticky_d;
  chk_mask_t        err_mask_q, err_mask_d, first_mask_q, first_mask_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, first_cyc_q, first_cyc_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d, err_cnt_q, err_cnt_d;

  always_comb begin
    cmp_mask             = '0;
    cmp_mask[ERR_DOUT]   = exp_data != MAX_DATA_W'(data_out);
    cmp_mask[ERR_WRACK]  = exp_wr_ack != wr_ack;
    cmp_mask[ERR_OVF]    = exp_ovf != overflow;
    cmp_mask[ERR_UDF]    = exp_udf != underflow;
    cmp_mask[ERR_FULL]   = exp_full != full;
    cmp_mask[ERR_AFULL]  = exp_afull != almostfull;
    cmp_mask[ERR_EMPTY]  = exp_empty != empty;
    cmp_mask[ERR_AEMPTY] = exp_aempty != almostempty;
  end

  // clr beats a same-cycle check, which then goes uncounted.
  always_comb begin
    cyc_d        = cyc_q + CNT_W'(1);
    err_pulse_d  = 1'b0;
    err_sticky_d = err_sticky_q;
    err_mask_d   = err_mask_q;
    first_mask_d = first_mask_q;
    first_cyc_d  = first_cyc_q;
    pass_cnt_d   = pass_cnt_q;
    err_cnt_d    = err_cnt_q;
    if (clr) begin
      err_sticky_d = 1'b0;
      err_mask_d   = '0;
      first_mask_d = '0;
      first_cyc_d  = '0;
      pass_cnt_d   = '0;
      err_cnt_d    = '0;
    end else if (check_valid_q) begin
      err_mask_d  = cmp_mask;
      err_pulse_d = |cmp_mask;
      if (|cmp_mask) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        if (!err_sticky_q) begin
          err_sticky_d = 1'b1;
          first_mask_d = cmp_mask;
          first_cyc_d  = cyc_q;
        end
      end else if (pass_cnt_q != '1) begin
        pass_cnt_d = pass_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      check_valid_q <= 1'b0;
      cyc_q         <= '0;
      err_pulse_q   <= 1'b0;
      err_sticky_q  <= 1'b0;
      err_mask_q    <= '0;
      first_mask_q  <= '0;
      first_cyc_q   <= '0;
      pass_cnt_q    <= '0;
      err_cnt_q     <= '0;
    end else begin
      check_valid_q <= 1'b1;
      cyc_q         <= cyc_d;
      err_pulse_q   <= err_pulse_d;
      err_sticky_q  <= err_sticky_d;
      err_mask_q    <= err_mask_d;
      first_mask_q  <= first_mask_d;
      first_cyc_q   <= first_cyc_d;
      pass_cnt_q    <= pass_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign err_pulse      = err_pulse_q;
  assign err_sticky     = err_sticky_q;
  assign err_mask       = err_mask_q;
  assign first_err_mask = first_mask_q;
  assign first_err_cyc  = first_cyc_q;
  assign pass_cnt       = pass_cnt_q;
  assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_fifo_check_monitor.sv
// Bench for fifo_check_monitor: a queue-based conforming FIFO feeds the checker,
// and per-bit corruption of its outputs provokes known mismatch masks.
module tb_fifo_check_monitor;

  localparam int Depth = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] data_in = '0;
  logic [7:0]  flip = '0;

  logic [15:0] fifoMem [$];
  logic [15:0] fifoDout = '0;
  logic        fifoAck = 1'b0, fifoOvf = 1'b0, fifoUdf = 1'b0;
  int          fifoCount = 0;
  bit          acceptWr, acceptRd;

  logic [15:0] data_out;
  logic        full, almostfull, empty, almostempty, wr_ack, overflow, underflow;

  logic        err_pulse, err_sticky, satPulse, satSticky;
  logic [7:0]  err_mask, first_err_mask, satMask, satFirstMask;
  logic [31:0] first_err_cyc, pass_cnt, err_cnt;
  logic [3:0]  satFirstCyc, satPass, satErr;

  always #5 clk = ~clk;

  // Conforming FIFO under check: registered status, combinational flags.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifoMem.delete();
      fifoDout  <= '0;
      fifoAck   <= 1'b0;
      fifoOvf   <= 1'b0;
      fifoUdf   <= 1'b0;
      fifoCount <= 0;
    end else begin
      acceptWr = wr_en && (fifoMem.size() < Depth);
      acceptRd = rd_en && (fifoMem.size() > 0);
      if (acceptRd) fifoDout <= fifoMem.pop_front();
      if (acceptWr) fifoMem.push_back(data_in);
      fifoAck   <= acceptWr;
      fifoOvf   <= wr_en && !acceptWr;
      fifoUdf   <= rd_en && !acceptRd;
      fifoCount <= fifoMem.size();
    end
  end

  assign data_out    = fifoDout ^ {15'b0, flip[0]};
  assign wr_ack      = fifoAck ^ flip[1];
  assign overflow    = fifoOvf ^ flip[2];
  assign underflow   = fifoUdf ^ flip[3];
  assign full        = (fifoCount == Depth) ^ flip[4];
  assign almostfull  = (fifoCount == Depth - 1) ^ flip[5];
  assign empty       = (fifoCount == 0) ^ flip[6];
  assign almostempty = (fifoCount == 1) ^ flip[7];

  fifo_check_monitor #(
    .DATA_W(16), .DEPTH(8), .AF_LVL(7), .AE_LVL(1), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .data_out(data_out), .full(full), .almostfull(almostfull),
    .empty(empty), .almostempty(almostempty), .wr_ack(wr_ack), .overflow(overflow),
    .underflow(underflow), .err_pulse(err_pulse), .err_sticky(err_sticky),
    .err_mask(err_mask), .first_err_mask(first_err_mask), .first_err_cyc(first_err_cyc),
    .pass_cnt(pass_cnt), .err_cnt(err_cnt)
  );

  fifo_check_monitor #(
    .DATA_W(16), .DEPTH(8), .AF_LVL(7), .AE_LVL(1), .CNT_W(4)
  ) dutSat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .data_out(data_out), .full(full), .almostfull(almostfull),
    .empty(empty), .almostempty(almostempty), .wr_ack(wr_ack), .overflow(overflow),
    .underflow(underflow), .err_pulse(satPulse), .err_sticky(satSticky),
    .err_mask(satMask), .first_err_mask(satFirstMask), .first_err_cyc(satFirstCyc),
    .pass_cnt(satPass), .err_cnt(satErr)
  );

  typedef struct {
    bit          wr;
    bit          rd;
    logic [15:0] din;
    logic [7:0]  flipBits;
    bit          clear;
    logic [7:0]  expMask;
  } vec_t;

  typedef struct {
    logic [7:0] mask;
    bit         counted;
    bit         cleared;
  } sbEntry_t;

  vec_t     vecs [$];
  sbEntry_t sbQueue [$];

  int         total = 0, bad = 0;
  int         edgeNum = 0, expPass = 0, expErr = 0, expFirstCyc = 0;
  bit         expSticky = 1'b0, expPulse = 1'b0;
  logic [7:0] expMask = '0, expFirstMask = '0;

  function automatic vec_t mk(bit w, bit r, logic [15:0] d, logic [7:0] f, bit c, logic [7:0] m);
    vec_t v;
    v.wr = w; v.rd = r; v.din = d; v.flipBits = f; v.clear = c; v.expMask = m;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".err_mask"}, err_mask, expMask);
    checkOutput({tag, ".err_pulse"}, err_pulse, expPulse);
    checkOutput({tag, ".err_sticky"}, err_sticky, expSticky);
    checkOutput({tag, ".pass_cnt"}, pass_cnt, expPass);
    checkOutput({tag, ".err_cnt"}, err_cnt, expErr);
    checkOutput({tag, ".first_err_mask"}, first_err_mask, expFirstMask);
    checkOutput({tag, ".first_err_cyc"}, first_err_cyc, expFirstCyc);
    checkOutput({tag, ".sat_pass_cnt"}, satPass, (expPass > 15) ? 15 : expPass);
    checkOutput({tag, ".sat_err_cnt"}, satErr, (expErr > 15) ? 15 : expErr);
  endtask

  // Drive at a falling edge, score the check made on the following rising edge.
  task automatic applyStimulus(input vec_t v, input string tag);
    sbEntry_t e;
    wr_en = v.wr; rd_en = v.rd; data_in = v.din; flip = v.flipBits; clr = v.clear;
    edgeNum++;
    sbQueue.push_back('{mask: v.expMask, counted: (edgeNum >= 2) && !v.clear, cleared: v.clear});
    @(posedge clk);
    #1;
    e = sbQueue.pop_front();
    expPulse = 1'b0;
    if (e.cleared) begin
      expMask = '0; expSticky = 1'b0; expFirstMask = '0; expFirstCyc = 0;
      expPass = 0; expErr = 0;
    end else if (e.counted) begin
      expMask  = e.mask;
      expPulse = |e.mask;
      if (e.mask != 8'h00) begin
        expErr++;
        if (!expSticky) begin
          expSticky = 1'b1; expFirstMask = e.mask; expFirstCyc = edgeNum - 1;
        end
      end else begin
        expPass++;
      end
    end
    checkAll(tag);
    @(negedge clk);
  endtask

  task automatic doReset(input string tag);
    rst_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0; flip = '0; data_in = '0;
    edgeNum = 0; expPass = 0; expErr = 0; expFirstCyc = 0;
    expSticky = 1'b0; expPulse = 1'b0; expMask = '0; expFirstMask = '0;
    #1;
    checkAll(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 0, 8'h00));
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(1, 0, 16'(i), 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 16'h0009, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 1, 16'hBEEF, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 16'h000A, 8'h00, 0, 8'h00));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 1, 16'h0000, 8'h00, 0, 8'h00));
    vecs.push_back(mk(0, 1, 16'h0000, 8'h00, 0, 8'h00));
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 0, 8'h00));
    vecs.push_back(mk(0, 0, 16'h0000, 8'h40, 0, 8'h40));
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 0, 16'h1234, 8'h00, 0, 8'h00));
    vecs.push_back(mk(0, 1, 16'h0000, 8'h02, 0, 8'h02));
    vecs.push_back(mk(0, 0, 16'h0000, 8'h01, 0, 8'h01));
    vecs.push_back(mk(0, 0, 16'h0000, 8'h88, 0, 8'h88));
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 0, 8'h00));

    #2;
    doReset("reset");
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], $sformatf("v%0d", i));

    applyStimulus(mk(0, 0, 16'h0000, 8'h40, 1, 8'h00), "clr");
    applyStimulus(mk(0, 0, 16'h0000, 8'h00, 0, 8'h00), "post_clr");

    applyStimulus(mk(1, 0, 16'h0011, 8'h00, 0, 8'h00), "fill1");
    applyStimulus(mk(1, 0, 16'h0012, 8'h00, 0, 8'h00), "fill2");
    applyStimulus(mk(1, 0, 16'h0013, 8'h00, 0, 8'h00), "fill3");
    doReset("mid_reset");
    applyStimulus(mk(1, 0, 16'h00AA, 8'hFF, 0, 8'h00), "exit_cycle");
    applyStimulus(mk(0, 1, 16'h0000, 8'h00, 0, 8'h00), "count1");
    applyStimulus(mk(0, 0, 16'h0000, 8'h00, 0, 8'h00), "readback");
    applyStimulus(mk(0, 0, 16'h0000, 8'h00, 0, 8'h00), "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
